matrix_rd_stream: RTL

- Read-side sequencer for the banked matrix RAM.
- On a start pulse it drives `re` into matrix_ctrl once per element, in row-major order, for one full matrix.
- It captures the returning bank data, selected by a delayed copy of `ram_sel`, into a small FIFO, and presents it as a valid/ready stream with end-of-row and end-of-matrix markers.
- Issue is credit-limited, so no element is lost under downstream backpressure.

---
 rtl/matrix_rd_stream_if.sv | 33 +++
 rtl/matrix_rd_stream.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/matrix_rd_stream_if.sv
// Read-stream bundle between matrix_rd_stream and its consumer.
// Optional coordinate sidebands are present when MATRIX_RD_COORD_EN is defined.
interface matrix_rd_stream_if #(
    parameter int unsigned DATA_W = 16
);
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;
    logic              rd_eol;
    logic              rd_eom;
`ifdef MATRIX_RD_COORD_EN
    logic [9:0]        rd_row;
    logic [9:0]        rd_col;
`endif

    // Producer side (matrix_rd_stream)
    modport master (
        input  rd_ready,
`ifdef MATRIX_RD_COORD_EN
        output rd_row, rd_col,
`endif
        output rd_data, rd_valid, rd_eol, rd_eom
    );

    // Consumer side
    modport slave (
        output rd_ready,
`ifdef MATRIX_RD_COORD_EN
        input  rd_row, rd_col,
`endif
        input  rd_data, rd_valid, rd_eol, rd_eom
    );
endinterface

// File: rtl/matrix_rd_stream.sv
// Read-side sequencer for the banked matrix RAM: issues one re per element in
// row-major order, realigns returning bank data with its {eol,eom} token and
// streams it out through a credit-limited FIFO.
// Optional feature macro: MATRIX_RD_COORD_EN (adds rd_row/rd_col per element).
module matrix_rd_stream #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                 CLK,
    input  logic                 RST_L,
    input  logic                 VDD,
    input  logic                 GND,
    input  logic                 start,
    input  logic [9:0]           max_row_count,
    input  logic [9:0]           max_col_count,
    input  logic [15:0]          ram_sel,
    input  logic [16*DATA_W-1:0] ram_rdata,
    output logic                 re,
    output logic                 busy,
    output logic                 done,
    matrix_rd_stream_if.master   rd_if
);

    localparam int unsigned PIPE_D = 1 + RD_LAT;
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
`ifdef MATRIX_RD_COORD_EN
    localparam int unsigned TOK_W  = 2 + 20;
`else
    localparam int unsigned TOK_W  = 2;
`endif
    localparam int unsigned FIFO_W = DATA_W + TOK_W;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

    state_t            r_state;
    logic [9:0]        r_max_row, r_max_col;
    logic [9:0]        r_ic, r_ir;
    logic              r_busy, r_done;
    logic [CNT_W-1:0]  r_credits;
    logic [PIPE_D-1:0] r_tok_v;
    logic [TOK_W-1:0]  r_tok [PIPE_D];
    logic [15:0]       r_sel_d [RD_LAT];
    logic [FIFO_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_re, w_hs, w_push, w_eol, w_eom, w_valid;
    logic [TOK_W-1:0]  w_tok_in;
    logic [3:0]        w_bank;
    logic [DATA_W-1:0] w_word;
    logic [CNT_W-1:0]  w_credits_nxt;
    logic [FIFO_W-1:0] w_head;
    logic              w_unused_tie;

    assign w_unused_tie  = VDD ^ GND;
    assign w_re          = (r_state == ST_RUN) && (r_credits < CNT_W'(DEPTH));
    assign w_valid       = (r_count != '0);
    assign w_hs          = w_valid && rd_if.rd_ready;
    assign w_eol         = (r_ic == r_max_col);
    assign w_eom         = w_eol && (r_ir == r_max_row);
    assign w_credits_nxt = r_credits + CNT_W'(w_re) - CNT_W'(w_hs);
    assign w_push        = r_tok_v[PIPE_D-1];
`ifdef MATRIX_RD_COORD_EN
    assign w_tok_in      = {r_ir, r_ic, w_eol, w_eom};
`else
    assign w_tok_in      = {w_eol, w_eom};
`endif

    // Frame sequencer: sample limits on start, walk (ir,ic) on each issue, drain, pulse done
    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            r_state   <= ST_IDLE;
            r_max_row <= '0;
            r_max_col <= '0;
            r_ic      <= '0;
            r_ir      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_max_row <= max_row_count;
                        r_max_col <= max_col_count;
                        r_ic      <= '0;
                        r_ir      <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_re) begin
                        if (w_eol) begin
                            r_ic <= '0;
                            if (w_eom) begin
                                r_ir    <= '0;
                                r_state <= ST_DRAIN;
                            end else begin
                                r_ir <= r_ir + 10'd1;
                            end
                        end else begin
                            r_ic <= r_ic + 10'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Zero credits means nothing in flight and the FIFO is empty
                    if (w_credits_nxt == '0) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Credits cover reads in flight plus FIFO occupancy, so the FIFO cannot overflow
    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            r_credits <= '0;
        end else begin
            r_credits <= w_credits_nxt;
        end
    end

    // Token pipe and ram_sel delay line align flags with the returning read data
    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            r_tok_v <= '0;
            for (int i = 0; i < int'(PIPE_D); i++) r_tok[i] <= '0;
            for (int i = 0; i < int'(RD_LAT); i++) r_sel_d[i] <= '0;
        end else begin
            r_tok_v  <= {r_tok_v[PIPE_D-2:0], w_re};
            r_tok[0] <= w_tok_in;
            for (int i = 1; i < int'(PIPE_D); i++) r_tok[i] <= r_tok[i-1];
            r_sel_d[0] <= ram_sel;
            for (int i = 1; i < int'(RD_LAT); i++) r_sel_d[i] <= r_sel_d[i-1];
        end
    end

    // Lowest set bit of the delayed select picks the bank; all-zero falls back to bank 0
    always_comb begin
        w_bank = '0;
        for (int k = 15; k >= 0; k--) begin
            if (r_sel_d[RD_LAT-1][k]) w_bank = 4'(k);
        end
    end

    assign w_word = ram_rdata[32'(w_bank)*DATA_W +: DATA_W];

    // Output FIFO; push and pop may coincide at any occupancy
    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {r_tok[PIPE_D-1], w_word};
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_hs) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_hs);
        end
    end

    // A push into a full FIFO without a pop means the credit accounting is broken
    always @(posedge CLK) begin
        if (RST_L && w_push && !w_hs) begin
            assert (r_count < CNT_W'(DEPTH))
            else $error("matrix_rd_stream: FIFO overflow");
        end
    end

    assign w_head         = r_mem[r_rd_ptr];
    assign rd_if.rd_data  = w_head[DATA_W-1:0];
    assign rd_if.rd_eom   = w_head[DATA_W];
    assign rd_if.rd_eol   = w_head[DATA_W+1];
`ifdef MATRIX_RD_COORD_EN
    assign rd_if.rd_col   = w_head[DATA_W+2 +: 10];
    assign rd_if.rd_row   = w_head[DATA_W+12 +: 10];
`endif
    assign rd_if.rd_valid = w_valid;
    assign re             = w_re;
    assign busy           = r_busy;
    assign done           = r_done;

endmodule
